// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states and PC source selects.
// Optional build macro: PIPE_PERF_CNT_EN (see pipe_stall_ctrl.sv).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
    localparam logic [1:0] PC_SEL_BR    = 2'd1;
    localparam logic [1:0] PC_SEL_SAVED = 2'd2;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Sequencer <-> datapath bundle: stall/handshake requests in,
// per-stage enables, flushes and PC control out.
interface pipe_stall_ctrl_if;

    logic       hz_stall;
    logic       br_taken;
    logic       imem_ready;
    logic       dmem_access;
    logic       dmem_ready;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       tgt_save;
    logic       imem_discard;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;

    modport master (
        input  hz_stall, br_taken, imem_ready,
        input  dmem_access, dmem_ready,
        output pc_en, pc_sel, tgt_save, imem_discard,
        output if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush
    );

    modport slave (
        output hz_stall, br_taken, imem_ready,
        output dmem_access, dmem_ready,
        input  pc_en, pc_sel, tgt_save, imem_discard,
        input  if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush
    );

endinterface

// File: rtl/pipe_wdt.sv
// Saturating consecutive-wait counter with clear and a sticky error flag
// that sets when the count reaches LIMIT.
module pipe_wdt #(
    parameter int WDT_W     = 8,
    parameter int WDT_LIMIT = 200
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic clr,
    output logic err
);

    localparam logic [WDT_W-1:0] LIM = WDT_W'(WDT_LIMIT);

    logic [WDT_W-1:0] cnt_q;
    logic [WDT_W-1:0] cnt_d;
    logic             err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    // Error is registered off the next count, so it is visible
    // in the cycle after the count reaches LIMIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | (cnt_d == LIM);
        end
    end

    assign err = err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central 5-stage pipeline sequencer: stage enables, bubbles, redirects.
// Optional build macro: PIPE_PERF_CNT_EN adds stall/redirect counters.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDT_W     = 8,
    parameter int WDT_LIMIT = 200,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    pipe_stall_ctrl_if.master bus,
    output logic             wdt_err,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_cnt,
`endif
    output logic [1:0]       state_o
);

    state_e     st_q, st_d;
    logic       redir_q, redir_d;
    logic       dm_stall, freeze, wdt_inc;
    logic       pc_en, tgt_save, discard;
    logic [1:0] pc_sel;
    logic       if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_flush;

    assign dm_stall = bus.dmem_access && !bus.dmem_ready;

    always_comb begin
        pc_en        = 1'b1;
        pc_sel       = PC_SEL_SEQ;
        tgt_save     = 1'b0;
        discard      = 1'b0;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        st_d         = st_q;
        redir_d      = redir_q;
        freeze = ((st_q == RUN || st_q == DRAIN) && dm_stall)
              || (st_q == MEM_WAIT && !bus.dmem_ready);
        if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            if (st_q == RUN)
                st_d = MEM_WAIT;
            // Stale fetch lands during the stall: drop it, redirect later.
            if (st_q == DRAIN && bus.imem_ready) begin
                discard = 1'b1;
                redir_d = 1'b1;
                st_d    = MEM_WAIT;
            end
        end else if (st_q == DRAIN) begin
            if_id_flush = 1'b1;
            if (bus.imem_ready) begin
                discard = 1'b1;
                pc_sel  = PC_SEL_SAVED;
                st_d    = RUN;
            end else begin
                pc_en = 1'b0;
            end
        end else begin
            st_d = RUN;
            priority case (1'b1)
                bus.hz_stall: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                redir_q: begin
                    pc_sel      = PC_SEL_SAVED;
                    if_id_flush = 1'b1;
                    redir_d     = 1'b0;
                end
                bus.br_taken && bus.imem_ready: begin
                    pc_sel      = PC_SEL_BR;
                    if_id_flush = 1'b1;
                end
                bus.br_taken: begin
                    tgt_save    = 1'b1;
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    st_d        = DRAIN;
                end
                !bus.imem_ready: begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= RUN;
            redir_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            redir_q <= redir_d;
        end
    end

    assign bus.pc_en        = rstn & pc_en;
    assign bus.pc_sel       = rstn ? pc_sel : PC_SEL_SEQ;
    assign bus.tgt_save     = rstn & tgt_save;
    assign bus.imem_discard = rstn & discard;
    assign bus.if_id_en     = rstn & if_id_en;
    assign bus.id_ex_en     = rstn & id_ex_en;
    assign bus.ex_mem_en    = rstn & ex_mem_en;
    assign bus.mem_wb_en    = rstn & mem_wb_en;
    assign bus.if_id_flush  = !rstn | if_id_flush;
    assign bus.id_ex_flush  = !rstn | id_ex_flush;
    assign bus.mem_wb_flush = !rstn | mem_wb_flush;
    assign state_o          = st_q;

    assign wdt_inc = (st_q == MEM_WAIT) || (st_q == DRAIN)
                  || (st_q == RUN && !bus.imem_ready);

    pipe_wdt #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (wdt_inc),
        .clr  (!wdt_inc),
        .err  (wdt_err)
    );

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
            redirect_cnt <= '0;
        end else begin
            if (!pc_en)
                stall_cycles <= stall_cycles + 1'b1;
            if (pc_en && pc_sel != PC_SEL_SEQ)
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: single-cycle vector table plus
// multi-cycle sequences for drain, memory wait, redirect and watchdog.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus ();
    logic       wdt_err;
    logic [1:0] state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_cnt;
`endif

    pipe_stall_ctrl #(
        .WDT_W     (8),
        .WDT_LIMIT (10),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .wdt_err      (wdt_err),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .redirect_cnt (redirect_cnt),
`endif
        .state_o      (state_o)
    );

    // {pc_en, pc_sel, tgt_save, discard, en x4, flush if/ex/wb, state}
    logic [13:0] ob;
    assign ob = {bus.pc_en, bus.pc_sel, bus.tgt_save, bus.imem_discard,
                 bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush,
                 state_o};

    localparam logic [13:0] NORM = 14'b1_00_0_0_1111_000_00;
    localparam logic [13:0] HZ   = 14'b0_00_0_0_0111_010_00;
    localparam logic [13:0] BR   = 14'b1_01_0_0_1111_100_00;
    localparam logic [13:0] NOIM = 14'b0_00_0_0_1111_100_00;
    localparam logic [13:0] RST  = 14'b0_00_0_0_0000_111_00;
    localparam logic [13:0] TGT  = 14'b0_00_1_0_1111_100_00;
    localparam logic [13:0] DRW  = 14'b0_00_0_0_1111_100_10;
    localparam logic [13:0] FRZR = 14'b0_00_0_0_0001_001_00;
    localparam logic [13:0] FRZM = 14'b0_00_0_0_0001_001_01;
    localparam logic [13:0] FRZD = 14'b0_00_0_0_0001_001_10;

    // inputs: {hz_stall, br_taken, imem_ready, dmem_access, dmem_ready}
    typedef struct {
        string       nm;
        logic [4:0]  in;
        logic [13:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic drive(input logic [4:0] v);
        {bus.hz_stall, bus.br_taken, bus.imem_ready,
         bus.dmem_access, bus.dmem_ready} = v;
    endtask

    task automatic chk(input string nm, input logic [13:0] exp);
        checks++;
        if (ob !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, ob, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [4:0] v,
                       input logic [13:0] exp);
        drive(v);
        #2;
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    vec_t tv[10];

    initial begin
        tv[0] = '{"idle",        5'b00100, NORM};
        tv[1] = '{"load_use",    5'b10100, HZ};
        tv[2] = '{"after_stall", 5'b00100, NORM};
        tv[3] = '{"br_ready",    5'b01100, BR};
        tv[4] = '{"br_hz",       5'b11100, HZ};
        tv[5] = '{"no_imem",     5'b00000, NOIM};
        tv[6] = '{"hz_no_imem",  5'b10000, HZ};
        tv[7] = '{"dmem_done",   5'b00111, NORM};
        tv[8] = '{"br_dmem_ok",  5'b01111, BR};
        tv[9] = '{"br_hz_noim",  5'b11000, HZ};

        drive(5'b00100);
        #3;
        chk("reset_out", RST);
        chkb("reset_wdt", wdt_err, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 10; i++)
            cyc(tv[i].nm, tv[i].in, tv[i].exp);

        // Branch while fetch waits, then stale fetch returns.
        cyc("drain_enter", 5'b01000, TGT);
        cyc("drain_w1",    5'b00000, DRW);
        cyc("drain_w2",    5'b00000, DRW);
        cyc("drain_exit",  5'b00100, 14'b1_10_0_1_1111_100_10);
        cyc("drain_run",   5'b00100, NORM);

        // Five-cycle data memory wait.
        cyc("mw_enter", 5'b00110, FRZR);
        for (int i = 0; i < 4; i++)
            cyc("mw_hold", 5'b00110, FRZM);
        cyc("mw_release", 5'b00111, 14'b1_00_0_0_1111_000_01);
        cyc("mw_run",     5'b00100, NORM);

        // Stale fetch during a data stall in DRAIN: redirect on exit.
        cyc("dr_enter",   5'b01000, TGT);
        cyc("dr_frz",     5'b00010, FRZD);
        cyc("dr_frz_im",  5'b00110, 14'b0_00_0_1_0001_001_10);
        cyc("dr_mw",      5'b00010, FRZM);
        cyc("dr_mw_exit", 5'b00011, 14'b1_10_0_0_1111_100_01);
        cyc("dr_run",     5'b00100, NORM);

        // Same, but load-use on the exit cycle defers the redirect.
        cyc("hr_enter",   5'b01000, TGT);
        cyc("hr_frz_im",  5'b00110, 14'b0_00_0_1_0001_001_10);
        cyc("hr_exit_hz", 5'b10111, 14'b0_00_0_0_0111_010_01);
        cyc("hr_retry",   5'b00100, 14'b1_10_0_0_1111_100_00);
        cyc("hr_run",     5'b00100, NORM);

        // Watchdog: counts MEM_WAIT cycles, error from the 11th.
        drive(5'b00110);
        #2;
        chk("wd_enter", FRZR);
        chkb("wd_enter_err", wdt_err, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 12; k++) begin
            drive(5'b00110);
            #2;
            chk("wd_wait", FRZM);
            chkb("wd_err", wdt_err, k >= 11);
            @(posedge clk);
            #1;
        end
        drive(5'b00111);
        #2;
        chkb("wd_err_release", wdt_err, 1'b1);
        @(posedge clk);
        #1;
        cyc("wd_run", 5'b00100, NORM);
        chkb("wd_err_sticky", wdt_err, 1'b1);

        // Reset asserted mid-DRAIN takes effect immediately.
        cyc("rd_enter", 5'b01000, TGT);
        drive(5'b00000);
        #2;
        chk("rd_drain", DRW);
        rstn = 1'b0;
        #1;
        chk("rd_async", RST);
        chkb("rd_wdt_clr", wdt_err, 1'b0);
        @(posedge clk);
        #1;
        chk("rd_held", RST);
        rstn = 1'b1;
        cyc("rd_run", 5'b00100, NORM);
        chkb("rd_wdt_low", wdt_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. Merges the load-use/branch stall request from the hazard detector, ID-stage branch redirects and instruction/data memory wait handshakes into per-stage register enables and bubble (flush) controls. Owns redirect-during-fetch-wait sequencing and a stall watchdog. Sits beside the hazard/forwarding logic and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
WDT_W, 8, width of the consecutive-wait counter
WDT_LIMIT, 200, consecutive wait cycles that set wdt_err; must be < 2**WDT_W
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk  in  1  core clock, rising edge
rstn  in  1  asynchronous active-low reset
hz_stall  in  1  stall request from the hazard detector
br_taken  in  1  branch/jump in ID resolved taken this cycle
imem_ready  in  1  fetch data for the current PC valid; held until accepted
dmem_access  in  1  MEM-stage instruction is a load or store
dmem_ready  in  1  data memory completes the MEM-stage access this cycle
pc_en  out  1  PC register load enable
pc_sel  out  2  PC source: 0 = PC+4, 1 = live branch target, 2 = saved target
tgt_save  out  1  datapath captures the branch target into the saved-target register
imem_discard  out  1  consume and drop the pending (stale) fetch
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, control bits 0)
wdt_err  out  1  sticky watchdog error
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (rstn low, async): state RUN, redir_pend 0, watchdog counter 0, wdt_err 0. While reset is asserted, all enables are 0, all flushes are 1, pc_sel 0, tgt_save 0 and imem_discard 0.
- Outputs are combinational from state plus inputs. State updates on the clk rising edge. Fetch is accepted when imem_ready && pc_en.
- States: RUN=0, MEM_WAIT=1, DRAIN=2.
- RUN uses the following priority, highest first:
  1. dmem_access && !dmem_ready: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_en=1 with mem_wb_flush=1; next state MEM_WAIT. A br_taken in the same cycle is ignored, because ID is frozen and will re-present it.
  2. hz_stall: pc_en=0, if_id_en=0, id_ex_flush=1, EX/MEM and MEM/WB advance. br_taken is ignored, because its operands are not yet valid.
  3. br_taken && imem_ready: pc_en=1, pc_sel=1, if_id_flush=1 (wrong-path instruction), all other stages advance.
  4. br_taken && !imem_ready: tgt_save=1, pc_en=0, if_id_flush=1, downstream advances; next state DRAIN.
  5. !imem_ready: pc_en=0, if_id_flush=1, downstream advances.
  6. Otherwise all enables are 1, pc_sel=0 and no flushes.
- MEM_WAIT: pc_en, if_id_en, id_ex_en and ex_mem_en stay 0; mem_wb_flush=1.
  - On dmem_ready, the cycle is evaluated as RUN with dmem treated as ready, and the next state is RUN.
  - If redir_pend is set, the exit cycle instead forces pc_en=1, pc_sel=2 and if_id_flush=1, then clears redir_pend.
  - hz_stall on the exit cycle still has priority over the redirect: the redirect is held and retried on the next cycle in RUN with the same pc_sel=2 behaviour.
- DRAIN: pc_en=0, if_id_flush=1, downstream advances. On imem_ready: imem_discard=1.
  - Same cycle, no dmem stall: pc_en=1, pc_sel=2, next state RUN.
  - DRAIN with dmem_access && !dmem_ready: apply the MEM_WAIT freeze. If imem_ready also arrives, assert imem_discard, set redir_pend and go to MEM_WAIT. Without imem_ready, stay in DRAIN, frozen.
- Watchdog:
  - The counter increments in any cycle in MEM_WAIT or DRAIN, or in RUN with !imem_ready. It clears on any other cycle and saturates at 2**WDT_W-1.
  - wdt_err is set when the counter equals WDT_LIMIT and holds until reset.
- dmem_access is ignored when no MEM instruction exists; the datapath guarantees that bubbles carry dmem_access=0.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W] and redirect_cnt[CNT_W].
  - stall_cycles increments every cycle with pc_en=0 outside reset.
  - redirect_cnt increments on every cycle with pc_sel≠0 && pc_en.
  - Both wrap modulo 2**CNT_W and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN/MEM_WAIT/DRAIN with encodings 0/1/2);
  - PC_SEL_SEQ=0, PC_SEL_BR=1, PC_SEL_SAVED=2.
- One sub-module, pipe_wdt: a saturating counter with a clear input and sticky error, parameterised by WDT_W and WDT_LIMIT.

Test Plan:
1. Load-use: hz_stall=1 for one cycle in RUN → pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; the next cycle is all enables 1.
2. Taken branch with imem_ready=1 → pc_sel=1, pc_en=1, if_id_flush=1 in the same cycle; with hz_stall=1 simultaneously → pc_sel=0, pc_en=0.
3. Branch while fetch waits: br_taken=1, imem_ready=0, then imem_ready after 3 cycles → tgt_save pulse; state DRAIN for 3 cycles; imem_discard=1 with pc_sel=2 and pc_en=1; state RUN.
4. dmem wait of 5 cycles → state MEM_WAIT, ex_mem_en=0 and mem_wb_flush=1 for 5 cycles; release cycle mem_wb_en=1 with no flush; no instruction lost or duplicated.
5. DRAIN plus dmem stall with imem_ready arriving during the stall → redir_pend set, imem_discard=1; on dmem_ready, pc_sel=2 and pc_en=1.
6. WDT_LIMIT=10, dmem_ready held 0 → wdt_err rises on the 11th wait cycle and stays 1 after dmem_ready; drops only on rstn low. Asserting rstn mid-DRAIN gives state RUN and all flushes 1 immediately.
